// File: rtl/load_store_unit.sv
// load_store_unit: handshaked memory-access stage of the pipeline.
// One outstanding load/store, wait-state tolerant, with timeout abort.
module load_store_unit #(
    parameter int ADDR_WIDTH    = 16,
    parameter int MAX_WAIT      = 255,
    parameter bit MISALIGN_TRAP = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  halt,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_store,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [4:0]            req_rd,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_rvalid,
    output logic                  resp_valid,
    output logic [4:0]            resp_rd,
    output logic [31:0]           resp_data,
    output logic                  resp_err,
    output logic [1:0]            resp_err_code,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, RESP} state_t;

    state_t                state_q, state_d;
    logic                  st_q;
    logic [1:0]            size_q;
    logic                  uns_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [4:0]            rd_q;
    logic [31:0]           data_q;
    logic                  err_q;
    logic [1:0]            code_q;
    logic [15:0]           cnt_q;

    logic                  accept;
    logic                  size_bad;
    logic                  misal;
    logic                  pre_err;
    logic [1:0]            pre_code;
    logic [ADDR_WIDTH-1:0] addr_al;
    logic [1:0]            lane;
    logic [3:0]            be;
    logic [31:0]           wd;
    logic [31:0]           rshift;
    logic [31:0]           ld_ext;
    logic                  term;
    logic                  cap;
    logic                  tmo;

    assign accept   = (state_q == IDLE) && req_valid && !halt;
    assign size_bad = (req_size == 2'b11);
    assign misal    = ((req_size == 2'b01) && req_addr[0]) ||
                      ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
    assign pre_err  = size_bad || (MISALIGN_TRAP && misal);
    assign pre_code = size_bad ? 2'b11 : (pre_err ? 2'b01 : 2'b00);

    // When trapping, misaligned requests never reach the bus, so forcing
    // natural alignment unconditionally is harmless.
    always_comb begin
        addr_al = req_addr;
        if (req_size == 2'b01)
            addr_al = {req_addr[ADDR_WIDTH-1:1], 1'b0};
        else if (req_size == 2'b10)
            addr_al = {req_addr[ADDR_WIDTH-1:2], 2'b00};
    end

    assign lane = addr_q[1:0];

    always_comb begin
        be = 4'b1111;
        wd = wdata_q;
        unique case (1'b1)
            (size_q == 2'b00): begin
                be = 4'b0001 << lane;
                wd = {4{wdata_q[7:0]}};
            end
            (size_q == 2'b01): begin
                be = lane[1] ? 4'b1100 : 4'b0011;
                wd = {2{wdata_q[15:0]}};
            end
            default: ;
        endcase
    end

    assign rshift = mem_rdata >> {lane, 3'b000};

    always_comb begin
        ld_ext = rshift;
        unique case (1'b1)
            (size_q == 2'b00):
                ld_ext = uns_q ? {24'b0, rshift[7:0]}
                               : {{24{rshift[7]}}, rshift[7:0]};
            (size_q == 2'b01):
                ld_ext = uns_q ? {16'b0, rshift[15:0]}
                               : {{16{rshift[15]}}, rshift[15:0]};
            default: ;
        endcase
    end

    assign term = (cnt_q == 16'(MAX_WAIT - 1));

    always_comb begin
        state_d = state_q;
        cap     = 1'b0;
        tmo     = 1'b0;
        unique case (state_q)
            IDLE:
                if (accept) state_d = pre_err ? RESP : REQ;
            REQ: begin
                // a completion on the terminal count beats the timeout
                if (mem_ready && (st_q || mem_rvalid)) begin
                    state_d = RESP;
                    cap     = !st_q;
                end else if (term) begin
                    state_d = RESP;
                    tmo     = 1'b1;
                end else if (mem_ready) begin
                    state_d = WAIT_R;
                end
            end
            WAIT_R: begin
                if (mem_rvalid) begin
                    state_d = RESP;
                    cap     = 1'b1;
                end else if (term) begin
                    state_d = RESP;
                    tmo     = 1'b1;
                end
            end
            RESP:
                if (!halt) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            code_q  <= 2'b00;
            cnt_q   <= '0;
        end else begin
            if (accept) begin
                st_q    <= req_store;
                size_q  <= req_size;
                uns_q   <= req_unsigned;
                addr_q  <= addr_al;
                wdata_q <= req_wdata;
                rd_q    <= req_rd;
                data_q  <= '0;
                err_q   <= pre_err;
                code_q  <= pre_code;
                cnt_q   <= '0;
            end
            if (state_q == REQ || state_q == WAIT_R)
                cnt_q <= cnt_q + 16'd1;
            if (cap)
                data_q <= ld_ext;
            if (tmo) begin
                err_q  <= 1'b1;
                code_q <= 2'b10;
            end
        end
    end

    logic in_req;
    logic in_resp;
    logic ok_load;

    assign in_req  = (state_q == REQ);
    assign in_resp = (state_q == RESP);
    assign ok_load = in_resp && !err_q && !st_q;

    assign req_ready     = (state_q == IDLE) && !halt;
    assign busy          = (state_q != IDLE);
    assign mem_valid     = in_req;
    assign mem_we        = in_req && st_q;
    assign mem_addr      = in_req ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
    assign mem_be        = in_req ? be : 4'b0000;
    assign mem_wdata     = in_req ? wd : 32'b0;
    assign resp_valid    = in_resp;
    assign resp_err      = in_resp && err_q;
    assign resp_err_code = in_resp ? code_q : 2'b00;
    assign resp_rd       = ok_load ? rd_q : 5'd0;
    assign resp_data     = ok_load ? data_q : 32'b0;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed transactions against two unit instances,
// one trapping and one aligning, checked each cycle against a timeline model.
module tb_load_store_unit;

    localparam int MAXW = 4;

    logic        clk;
    logic        rst_n;
    logic        halt;
    logic        req_valid;
    logic        req_store;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;

    typedef struct packed {
        logic        req_ready;
        logic        mem_valid;
        logic        mem_we;
        logic [15:0] mem_addr;
        logic [3:0]  mem_be;
        logic [31:0] mem_wdata;
        logic        resp_valid;
        logic [4:0]  resp_rd;
        logic [31:0] resp_data;
        logic        resp_err;
        logic [1:0]  resp_code;
        logic        busy;
    } obs_t;

    obs_t a1, a0;

    load_store_unit #(
        .ADDR_WIDTH(16), .MAX_WAIT(MAXW), .MISALIGN_TRAP(1'b1)
    ) u1 (
        .clk(clk), .rst_n(rst_n), .halt(halt),
        .req_valid(req_valid), .req_ready(a1.req_ready),
        .req_store(req_store), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_valid(a1.mem_valid), .mem_ready(mem_ready),
        .mem_we(a1.mem_we), .mem_addr(a1.mem_addr),
        .mem_be(a1.mem_be), .mem_wdata(a1.mem_wdata),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .resp_valid(a1.resp_valid), .resp_rd(a1.resp_rd),
        .resp_data(a1.resp_data), .resp_err(a1.resp_err),
        .resp_err_code(a1.resp_code), .busy(a1.busy)
    );

    load_store_unit #(
        .ADDR_WIDTH(16), .MAX_WAIT(MAXW), .MISALIGN_TRAP(1'b0)
    ) u0 (
        .clk(clk), .rst_n(rst_n), .halt(halt),
        .req_valid(req_valid), .req_ready(a0.req_ready),
        .req_store(req_store), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_valid(a0.mem_valid), .mem_ready(mem_ready),
        .mem_we(a0.mem_we), .mem_addr(a0.mem_addr),
        .mem_be(a0.mem_be), .mem_wdata(a0.mem_wdata),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .resp_valid(a0.resp_valid), .resp_rd(a0.resp_rd),
        .resp_data(a0.resp_data), .resp_err(a0.resp_err),
        .resp_err_code(a0.resp_code), .busy(a0.busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_run;
    int n_fail;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // A transaction and the bus behaviour the bench plays back for it.
    // rdy/rv are cycle offsets after the accept cycle (rv < 0: never).
    typedef struct {
        bit          store;
        logic [1:0]  size;
        bit          uns;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        int          rdy;
        int          rv;
        logic [31:0] rdata;
        int          hold;
    } txn_t;

    // Transaction timeline: cycle 0 = accept, mem_valid on 1..mv,
    // response starts at rs.
    typedef struct {
        int          rs;
        int          mv;
        logic        err;
        logic [1:0]  code;
        logic [31:0] data;
        logic [4:0]  rd;
        logic [15:0] aal;
    } tl_t;

    function automatic logic [31:0] f_load(logic [31:0] rdata, logic [1:0] sz,
                                           logic [1:0] a, bit uns);
        logic [31:0] s;
        s = rdata >> (8 * a);
        if (sz == 2'd0) return uns ? (s & 32'hFF) : 32'(signed'(s[7:0]));
        if (sz == 2'd1) return uns ? (s & 32'hFFFF) : 32'(signed'(s[15:0]));
        return s;
    endfunction

    function automatic logic [3:0] f_be(logic [1:0] sz, logic [1:0] a);
        if (sz == 2'd0) return 4'(1 << a);
        if (sz == 2'd1) return (a >= 2) ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] f_wd(logic [1:0] sz, logic [31:0] w);
        if (sz == 2'd0) return (w & 32'hFF) * 32'h0101_0101;
        if (sz == 2'd1) return (w & 32'hFFFF) * 32'h0001_0001;
        return w;
    endfunction

    function automatic tl_t f_tl(txn_t t, bit trap);
        tl_t tl;
        int r, v;
        bit mis;
        tl.mv = 0; tl.err = 0; tl.code = 0; tl.data = 0; tl.rs = 1;
        mis = (t.size == 1 && t.addr % 2 != 0) || (t.size == 2 && t.addr % 4 != 0);
        tl.aal = t.addr;
        if (t.size == 1) tl.aal = t.addr & 16'hFFFE;
        if (t.size == 2) tl.aal = t.addr & 16'hFFFC;
        r = 1 + t.rdy;
        v = (t.rv < 0) ? 1000000 : 1 + t.rv;
        if (t.size == 3) begin
            tl.err = 1; tl.code = 2'b11;
        end else if (trap && mis) begin
            tl.err = 1; tl.code = 2'b01;
        end else if (r > MAXW) begin
            tl.mv = MAXW; tl.err = 1; tl.code = 2'b10; tl.rs = MAXW + 1;
        end else begin
            tl.mv = r;
            if (t.store) tl.rs = r + 1;
            else if (v <= MAXW) begin
                tl.rs = ((v > r) ? v : r) + 1;
                tl.data = f_load(t.rdata, t.size, tl.aal[1:0], t.uns);
            end else begin
                tl.err = 1; tl.code = 2'b10; tl.rs = MAXW + 1;
            end
        end
        tl.rd = (tl.err || t.store) ? 5'd0 : t.rd;
        if (tl.err || t.store) tl.data = 0;
        return tl;
    endfunction

    function automatic obs_t f_exp(txn_t t, tl_t tl, int k, logic h);
        obs_t e;
        int re;
        e = '0;
        re = tl.rs + 1 + t.hold;
        e.req_ready  = (k == 0 || k >= re) && !h;
        e.busy       = (k >= 1 && k < re);
        e.mem_valid  = (k >= 1 && k <= tl.mv);
        e.resp_valid = (k >= tl.rs && k < re);
        if (e.mem_valid) begin
            e.mem_we    = t.store;
            e.mem_addr  = tl.aal & 16'hFFFC;
            e.mem_be    = f_be(t.size, tl.aal[1:0]);
            e.mem_wdata = f_wd(t.size, t.wdata);
        end
        if (e.resp_valid) begin
            e.resp_rd   = tl.rd;
            e.resp_data = tl.data;
            e.resp_err  = tl.err;
            e.resp_code = tl.code;
        end
        return e;
    endfunction

    task automatic cmp(input string p, input obs_t a, input obs_t e);
        chk({p, ".req_ready"}, 32'(a.req_ready), 32'(e.req_ready));
        chk({p, ".busy"}, 32'(a.busy), 32'(e.busy));
        chk({p, ".mem_valid"}, 32'(a.mem_valid), 32'(e.mem_valid));
        chk({p, ".resp_valid"}, 32'(a.resp_valid), 32'(e.resp_valid));
        if (e.mem_valid) begin
            chk({p, ".mem_we"}, 32'(a.mem_we), 32'(e.mem_we));
            chk({p, ".mem_addr"}, 32'(a.mem_addr), 32'(e.mem_addr));
            chk({p, ".mem_be"}, 32'(a.mem_be), 32'(e.mem_be));
            chk({p, ".mem_wdata"}, a.mem_wdata, e.mem_wdata);
        end
        if (e.resp_valid) begin
            chk({p, ".resp_rd"}, 32'(a.resp_rd), 32'(e.resp_rd));
            chk({p, ".resp_data"}, a.resp_data, e.resp_data);
            chk({p, ".resp_err"}, 32'(a.resp_err), 32'(e.resp_err));
            chk({p, ".resp_code"}, 32'(a.resp_code), 32'(e.resp_code));
        end
    endtask

    txn_t cur;
    tl_t  tl1, tl0;
    int   kk;
    bit   chk_on;

    always @(negedge clk) begin
        if (chk_on) begin
            cmp("u1", a1, f_exp(cur, tl1, kk, halt));
            cmp("u0", a0, f_exp(cur, tl0, kk, halt));
        end
    end

    // Observations from the trapping instance for literal pins.
    logic [15:0] o_addr, o0_addr;
    logic [3:0]  o_be;
    logic [31:0] o_wd, o_data;
    logic [4:0]  o_rd;
    logic        o_err;
    logic [1:0]  o_code;
    int          o_rs, o_mv, o_rvn;

    task automatic run(input txn_t t);
        int n, re0, re1;
        tl1 = f_tl(t, 1'b1);
        tl0 = f_tl(t, 1'b0);
        re1 = tl1.rs + 1 + t.hold;
        re0 = tl0.rs + 1 + t.hold;
        n = (re1 > re0) ? re1 : re0;
        cur = t;
        o_rs = -1; o_mv = 0; o_rvn = 0;
        o_addr = 0; o0_addr = 0; o_be = 0; o_wd = 0;
        o_data = 0; o_rd = 0; o_err = 0; o_code = 0;
        for (int k = 0; k < n; k++) begin
            kk           = k;
            req_valid    = (k == 0);
            req_store    = t.store;
            req_size     = t.size;
            req_unsigned = t.uns;
            req_addr     = t.addr;
            req_wdata    = t.wdata;
            req_rd       = t.rd;
            mem_ready    = (k == 1 + t.rdy);
            mem_rvalid   = (t.rv >= 0) && (k == 1 + t.rv);
            mem_rdata    = t.rdata;
            halt         = (k >= tl1.rs) && (k < tl1.rs + t.hold);
            chk_on       = 1'b1;
            @(negedge clk);
            if (k == 1) begin
                o_addr = a1.mem_addr; o_be = a1.mem_be;
                o_wd = a1.mem_wdata; o0_addr = a0.mem_addr;
            end
            if (a1.mem_valid) o_mv++;
            if (a1.resp_valid) begin
                o_rvn++;
                if (o_rs < 0) begin
                    o_rs = k; o_data = a1.resp_data; o_rd = a1.resp_rd;
                    o_err = a1.resp_err; o_code = a1.resp_code;
                end
            end
            @(posedge clk);
            #1;
        end
        chk_on     = 1'b0;
        req_valid  = 1'b0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        halt       = 1'b0;
    endtask

    function automatic txn_t mk(bit st, logic [1:0] sz, bit u, logic [15:0] ad,
                                logic [31:0] wd, logic [4:0] rd, int rdy,
                                int rv, logic [31:0] rdata, int hold);
        txn_t t;
        t.store = st; t.size = sz; t.uns = u; t.addr = ad; t.wdata = wd;
        t.rd = rd; t.rdy = rdy; t.rv = rv; t.rdata = rdata; t.hold = hold;
        return t;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        n_run = 0; n_fail = 0; chk_on = 0; kk = 0;
        rst_n = 0; halt = 0; req_valid = 0; req_store = 0; req_size = 0;
        req_unsigned = 0; req_addr = 0; req_wdata = 0; req_rd = 0;
        mem_ready = 0; mem_rdata = 0; mem_rvalid = 0;
        #12;
        chk("rst.u1.req_ready", 32'(a1.req_ready), 1);
        chk("rst.u1.others", 32'(a1 & ~{1'b1, 96'b0}), 0);
        chk("rst.u0.others", 32'(a0 & ~{1'b1, 96'b0}), 0);
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;

        // signed byte load, zero wait
        run(mk(0, 2'd0, 0, 16'h0013, 0, 5'd5, 0, 0, 32'h80FF_1234, 0));
        chk("lb.addr", 32'(o_addr), 32'h0010);
        chk("lb.be", 32'(o_be), 32'b1000);
        chk("lb.data", o_data, 32'hFFFF_FF80);
        chk("lb.rd", 32'(o_rd), 5);
        chk("lb.lat", o_rs, 2);
        // store half, ready delayed 3 cycles
        run(mk(1, 2'd1, 0, 16'h0102, 32'hDEAD_BEEF, 5'd7, 3, -1, 0, 0));
        chk("sh.be", 32'(o_be), 32'b1100);
        chk("sh.wdata", o_wd, 32'hBEEF_BEEF);
        chk("sh.mvcyc", o_mv, 4);
        chk("sh.rd", 32'(o_rd), 0);
        chk("sh.err", 32'(o_err), 0);
        // misaligned word load: trap vs align
        run(mk(0, 2'd2, 0, 16'h0006, 0, 5'd9, 0, 0, 32'h1111_2222, 0));
        chk("mis.mvcyc", o_mv, 0);
        chk("mis.code", 32'(o_code), 2'b01);
        chk("mis.data", o_data, 0);
        chk("mis.u0addr", 32'(o0_addr), 32'h0004);
        // timeout in WAIT_R, then rvalid on the terminal cycle
        run(mk(0, 2'd2, 0, 16'h0020, 0, 5'd4, 0, -1, 32'h1234_5678, 0));
        chk("tmo.code", 32'(o_code), 2'b10);
        chk("tmo.rs", o_rs, MAXW + 1);
        run(mk(0, 2'd2, 0, 16'h0020, 0, 5'd4, 0, 3, 32'h1234_5678, 0));
        chk("term.err", 32'(o_err), 0);
        chk("term.data", o_data, 32'h1234_5678);
        // extension variants
        run(mk(0, 2'd0, 1, 16'h0021, 0, 5'd1, 0, 0, 32'h0000_9A00, 0));
        chk("lbu.data", o_data, 32'h0000_009A);
        run(mk(0, 2'd1, 0, 16'h0022, 0, 5'd2, 1, 2, 32'h8001_0000, 0));
        chk("lh.data", o_data, 32'hFFFF_8001);
        run(mk(0, 2'd1, 1, 16'h0022, 0, 5'd3, 0, 1, 32'h8001_0000, 0));
        chk("lhu.data", o_data, 32'h0000_8001);
        run(mk(0, 2'd2, 1, 16'h0044, 0, 5'd6, 0, 0, 32'h8000_0000, 0));
        chk("lwu.data", o_data, 32'h8000_0000);
        run(mk(1, 2'd0, 0, 16'h0031, 32'h1234_56A5, 5'd8, 0, -1, 0, 0));
        chk("sb.be", 32'(o_be), 32'b0010);
        chk("sb.wdata", o_wd, 32'hA5A5_A5A5);
        // store never accepted by the bus
        run(mk(1, 2'd2, 0, 16'h0050, 32'h0BAD_F00D, 5'd0, 99, -1, 0, 0));
        chk("stmo.mvcyc", o_mv, MAXW);
        chk("stmo.code", 32'(o_code), 2'b10);
        // illegal size, misaligned half
        run(mk(0, 2'd3, 0, 16'h0060, 0, 5'd10, 0, 0, 0, 0));
        chk("ill.code", 32'(o_code), 2'b11);
        run(mk(0, 2'd1, 0, 16'h0101, 0, 5'd11, 0, 0, 32'h0000_F00D, 0));
        chk("mish.code", 32'(o_code), 2'b01);
        // halt held through RESP for 5 cycles
        run(mk(0, 2'd2, 0, 16'h0040, 0, 5'd12, 0, 0, 32'hCAFE_0001, 5));
        chk("halt.rvcyc", o_rvn, 6);
        chk("halt.data", o_data, 32'hCAFE_0001);

        // halt in IDLE blocks acceptance
        halt = 1; req_valid = 1; req_size = 2'd2; req_store = 0; req_addr = 0;
        @(negedge clk);
        chk("hidle.ready", 32'(a1.req_ready), 0);
        @(posedge clk); #1;
        chk("hidle.busy", 32'(a1.busy), 0);
        halt = 0; req_valid = 0;
        @(posedge clk); #1;

        // reset pulse while waiting for read data
        req_valid = 1; req_addr = 16'h0070; req_rd = 5'd3;
        @(posedge clk); #1;
        req_valid = 0; mem_ready = 1;
        @(posedge clk); #1;
        mem_ready = 0;
        chk("wr.busy", 32'(a1.busy), 1);
        #2 rst_n = 0;
        #1;
        chk("wr.rst.ready", 32'(a1.req_ready), 1);
        chk("wr.rst.u1", 32'(|(a1 & ~{1'b1, 96'b0})), 0);
        chk("wr.rst.u0", 32'(|(a0 & ~{1'b1, 96'b0})), 0);
        @(posedge clk); #1;
        rst_n = 1;
        mem_rvalid = 1; mem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        chk("wr.late.resp", 32'(a1.resp_valid), 0);
        chk("wr.late.ready", 32'(a1.req_ready), 1);
        @(posedge clk); #1;
        mem_rvalid = 0;
        @(negedge clk);
        chk("wr.late.busy", 32'(a1.busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Parametrised memory-access stage for the RISC-V pipeline. It replaces the combinational memory-access decode with a handshaked, multi-cycle unit.
- Accepts one load/store request from execute, drives a valid/ready data-memory bus with byte enables, tolerates wait states, and returns a sign/zero-extended load result or completion/error to write-back.
- Asserts busy so the pipeline stalls while a transaction is outstanding.

Parameters:
- ADDR_WIDTH, 16, data-memory byte-address width.
- MAX_WAIT, 255, cycles allowed in REQ+WAIT_R before timeout abort (1..65535).
- MISALIGN_TRAP, 1, 1 = misaligned access raises an error; 0 = low address bits are silently cleared to natural alignment.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, active-low
- halt  in  1  pipeline halt
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_store  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_unsigned  in  1  zero-extend load result
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  32  store data, right-aligned
- req_rd  in  5  load destination register
- mem_valid  out  1  bus request
- mem_ready  in  1  bus accepts request
- mem_we  out  1  write strobe
- mem_addr  out  ADDR_WIDTH  word-aligned address (low 2 bits 0)
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated write data
- mem_rdata  in  32  read data
- mem_rvalid  in  1  read data valid
- resp_valid  out  1  response present
- resp_rd  out  5  destination register (0 for stores and errors)
- resp_data  out  32  extended load data (0 for stores and errors)
- resp_err  out  1  error flag
- resp_err_code  out  2  01 misaligned, 10 timeout, 11 illegal size
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset:
  - Async, active-low. State is IDLE; every output is 0 except req_ready = 1.
  - Wait counter and captured request are cleared.
  - Any in-flight transaction is dropped and no response is issued.
- FSM states: IDLE, REQ, WAIT_R, RESP.
- IDLE:
  - req_ready = !halt.
  - A request is accepted on req_valid & req_ready, and all req_* fields are registered.
  - If req_size = 11, or (MISALIGN_TRAP = 1 and the access is misaligned), the next state is RESP with the error set. Misaligned means half with addr[0] = 1, or word with addr[1:0] != 00.
  - Otherwise the next state is REQ.
- REQ:
  - mem_valid = 1; mem_we, mem_addr, mem_be and mem_wdata are driven from the registered request and held stable until mem_ready.
  - On mem_valid & mem_ready:
    - store → RESP.
    - load with mem_rvalid in the same cycle → capture data, then RESP.
    - load otherwise → WAIT_R.
- WAIT_R: mem_valid = 0. On mem_rvalid, capture data and go to RESP.
- Timeout:
  - A 16-bit counter clears on entry to REQ and increments each cycle in REQ or WAIT_R.
  - When it reaches MAX_WAIT with no completing event that cycle, the transaction aborts: mem_valid drops the next cycle, the state goes to RESP, and the error code is 10.
  - A completion in the same cycle as the terminal count wins over the timeout.
- RESP:
  - resp_valid = 1 for one cycle, then IDLE.
  - If halt = 1, RESP and all resp_* outputs are held until halt falls.
  - A new request cannot be accepted in the RESP cycle, so minimum issue interval is 3 cycles for stores and 3 for zero-wait loads.
- Byte lanes (a = addr[1:0]):
  - Byte: be = 0001 << a; wdata = {4{wdata[7:0]}}.
  - Half: be = a[1] ? 1100 : 0011; wdata = {2{wdata[15:0]}}.
  - Word: be = 1111; wdata unchanged.
  - MISALIGN_TRAP = 0: half forces a[0] = 0, word forces a = 00, before lane selection.
- Load extraction:
  - Shift mem_rdata right by 8·a, then take 8/16/32 bits.
  - Sign-extend unless req_unsigned. req_unsigned is ignored for word.
- halt: affects only IDLE acceptance and RESP exit. Bus handshakes and the timeout counter continue during halt, so an outstanding bus transaction always completes.

Test Plan:
- Load byte, addr 0x0013, signed, mem_rdata 0x80FF_1234, zero-wait ready+rvalid → mem_addr 0x0010, be 1000, resp_data 0xFFFF_FF80, resp_rd echoed, resp_valid 2 cycles after accept.
- Store half, addr 0x0102, wdata 0xDEAD_BEEF, mem_ready delayed 3 cycles → mem_valid/addr/be/wdata stable 4 cycles; be 1100, wdata 0xBEEF_BEEF; resp_valid with resp_rd 0, resp_err 0.
- Load word addr 0x0006 with MISALIGN_TRAP=1 → no mem_valid ever; resp_err 1, code 01, resp_data 0. Same with MISALIGN_TRAP=0 → mem_addr 0x0004, be 1111, normal response.
- Load, MAX_WAIT=4, mem_ready 1 cycle then never rvalid → resp_err 1, code 10, busy drops after RESP. Repeat with rvalid on the terminal cycle → normal data, no error.
- halt asserted during RESP for 5 cycles → resp_valid and data held 5 cycles, req_ready 0 throughout; halt in IDLE with req_valid → no accept.
- rst_n pulsed low while in WAIT_R → all outputs 0 immediately, req_ready 1 after release, late mem_rvalid ignored.
